transformation_fsm: RTL

- Control FSM that sequences the feature x weight transformation in the GCN datapath.
- Sits directly upstream of the Counter stage and drives its three control inputs: enable_weight_counter, enable_feature_counter, read_feature_or_weight.
- Watches the counter's weight_count/feature_count and emits scratch-pad-load and product-write strobes to the datapath.
- One pass computes all FEATURE_ROWS x WEIGHT_COLS products, then holds done until reset.

---
 rtl/gcn_pkg.sv | 22 ++
 rtl/transformation_fsm_if.sv | 33 +++
 rtl/transformation_fsm.sv | 98 +++++++++
 3 files changed

// File: rtl/gcn_pkg.sv
// Shared types and constants for the GCN transformation control path.
package gcn_pkg;

    localparam int unsigned FEATURE_ROWS_DEFAULT          = 6;
    localparam int unsigned WEIGHT_COLS_DEFAULT           = 3;
    localparam int unsigned COUNTER_WEIGHT_WIDTH_DEFAULT  = $clog2(WEIGHT_COLS_DEFAULT);
    localparam int unsigned COUNTER_FEATURE_WIDTH_DEFAULT = $clog2(FEATURE_ROWS_DEFAULT);

    // Start of the feature region in the shared memory; weights sit at 0.
    localparam logic [9:0] FEATURE_BASE_ADDR = 10'b10_0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_W  = 3'd1,
        LOAD_SP = 3'd2,
        READ_F  = 3'd3,
        COMPUTE = 3'd4,
        INC_W   = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/transformation_fsm_if.sv
// Control/status bundle between the transformation FSM and its surroundings.
interface transformation_fsm_if
    import gcn_pkg::*;
#(
    parameter int unsigned COUNTER_WEIGHT_WIDTH  = COUNTER_WEIGHT_WIDTH_DEFAULT,
    parameter int unsigned COUNTER_FEATURE_WIDTH = COUNTER_FEATURE_WIDTH_DEFAULT
);
    logic                             start;
    logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count;
    logic [COUNTER_FEATURE_WIDTH-1:0] feature_count;
    logic                             enable_weight_counter;
    logic                             enable_feature_counter;
    logic                             read_feature_or_weight;
    logic                             enable_scratch_pad;
    logic                             enable_write_fm_wm_prod;
    logic                             busy;
    logic                             done;

    // FSM side.
    modport master (
        input  start, weight_count, feature_count,
        output enable_weight_counter, enable_feature_counter, read_feature_or_weight,
               enable_scratch_pad, enable_write_fm_wm_prod, busy, done
    );

    // Counter / datapath / host side.
    modport slave (
        output start, weight_count, feature_count,
        input  enable_weight_counter, enable_feature_counter, read_feature_or_weight,
               enable_scratch_pad, enable_write_fm_wm_prod, busy, done
    );

endinterface

// File: rtl/transformation_fsm.sv
// Sequences one feature x weight pass: per weight column, load the column into
// the scratch pad, then read and multiply every feature row; holds done until reset.
module transformation_fsm
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS          = FEATURE_ROWS_DEFAULT,
    parameter int unsigned WEIGHT_COLS           = WEIGHT_COLS_DEFAULT,
    parameter int unsigned COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int unsigned COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    transformation_fsm_if.master bus
);

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_F = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_W = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    state_t state_q;
    state_t state_d;

    logic more_rows;
    logic more_cols;

    assign more_rows = (bus.feature_count < LAST_F);
    assign more_cols = (bus.weight_count < LAST_W);

    // State register; reset returns to IDLE together with the Counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only matters in IDLE; DONE is terminal until reset.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = bus.start ? READ_W : IDLE;
            READ_W:  state_d = LOAD_SP;
            LOAD_SP: state_d = READ_F;
            READ_F:  state_d = COMPUTE;
            COMPUTE: begin
                if (more_rows) begin
                    state_d = READ_F;
                end else if (more_cols) begin
                    state_d = INC_W;
                end else begin
                    state_d = DONE;
                end
            end
            INC_W:   state_d = READ_W;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state (feature enable also looks at the row count).
    always_comb begin
        bus.enable_weight_counter   = 1'b0;
        bus.enable_feature_counter  = 1'b0;
        bus.read_feature_or_weight  = 1'b0;
        bus.enable_scratch_pad      = 1'b0;
        bus.enable_write_fm_wm_prod = 1'b0;
        bus.busy                    = 1'b0;
        bus.done                    = 1'b0;
        case (state_q)
            READ_W: begin
                bus.busy = 1'b1;
            end
            LOAD_SP: begin
                bus.busy               = 1'b1;
                bus.enable_scratch_pad = 1'b1;
            end
            READ_F: begin
                bus.busy                   = 1'b1;
                bus.read_feature_or_weight = 1'b1;
            end
            COMPUTE: begin
                bus.busy                    = 1'b1;
                bus.read_feature_or_weight  = 1'b1;
                bus.enable_write_fm_wm_prod = 1'b1;
                bus.enable_feature_counter  = more_rows;
            end
            INC_W: begin
                bus.busy                  = 1'b1;
                bus.enable_weight_counter = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
